rggen_atomic_wide_register: RTL and testbench

RGGEN_ATOMIC_WIDE_REGISTER -- requirements
Module: rggen_atomic_wide_register

---
 rtl/rggen_atomic_wide_register.sv | 179 +++++++++++++++++
 tb/tb_rggen_atomic_wide_register.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_atomic_wide_register.sv
// Multi-word bus register: writes gather in holding slots and commit atomically on the last word;
// reads of word 0 optionally snapshot the whole register so later words return a coherent value.
module rggen_atomic_wide_register #(
    parameter logic                     READABLE       = 1'b1,
    parameter logic                     WRITABLE       = 1'b1,
    parameter int                       ADDRESS_WIDTH  = 8,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter int                       BUS_WIDTH      = 32,
    parameter int                       WORDS          = 2,
    parameter int                       DATA_WIDTH     = BUS_WIDTH * WORDS,
    parameter logic                     ATOMIC_READ    = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_register_valid,
    input  logic [1:0]               i_register_access,
    input  logic [ADDRESS_WIDTH-1:0] i_register_address,
    input  logic [BUS_WIDTH-1:0]     i_register_write_data,
    input  logic [BUS_WIDTH-1:0]     i_register_strobe,
    output logic                     o_register_active,
    output logic                     o_register_ready,
    output logic [1:0]               o_register_status,
    output logic [BUS_WIDTH-1:0]     o_register_read_data,
    output logic [DATA_WIDTH-1:0]    o_register_value,
    output logic                     o_bit_field_write_valid,
    output logic                     o_bit_field_read_valid,
    output logic [DATA_WIDTH-1:0]    o_bit_field_mask,
    output logic [DATA_WIDTH-1:0]    o_bit_field_write_data,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_read_data,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_value
);

    localparam int BYTE_LSB    = $clog2(BUS_WIDTH / 8);
    localparam int FULL_WIDTH  = BUS_WIDTH * WORDS;
    localparam int SLOTS       = (WORDS > 1) ? WORDS - 1 : 1;
    localparam int INDEX_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic                     hit;
    logic [INDEX_WIDTH-1:0]   word_index;
    logic [ADDRESS_WIDTH-1:0] word_addr;
    logic                     is_last;
    logic                     read_req;
    logic                     write_req;
    logic                     read_ok;
    logic                     write_ok;
    logic                     commit;
    logic                     slot_write;
    logic                     snap_capture;
    logic                     use_snap;

    logic [SLOTS-1:0][BUS_WIDTH-1:0] slot_data_d,   slot_data_q;
    logic [SLOTS-1:0][BUS_WIDTH-1:0] slot_strobe_d, slot_strobe_q;
    logic [SLOTS-1:0]                pending_d,     pending_q;
    logic [FULL_WIDTH-1:0]           snap_data_d,   snap_data_q;
    logic                            snap_valid_d,  snap_valid_q;

    logic [FULL_WIDTH-1:0] full_read;
    logic [FULL_WIDTH-1:0] commit_data;
    logic [FULL_WIDTH-1:0] commit_mask;
    logic [BUS_WIDTH-1:0]  live_word;
    logic [BUS_WIDTH-1:0]  snap_word;

    // Byte-lane LSBs are shifted away so any byte address inside a word hits it.
    always_comb begin
        hit        = 1'b0;
        word_index = '0;
        word_addr  = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            word_addr = OFFSET_ADDRESS + ADDRESS_WIDTH'(k * (BUS_WIDTH / 8));
            if ((i_register_address >> BYTE_LSB) == (word_addr >> BYTE_LSB)) begin
                hit        = 1'b1;
                word_index = INDEX_WIDTH'(k);
            end
        end
    end

    always_comb begin
        is_last      = (word_index == INDEX_WIDTH'(WORDS - 1));
        read_req     = o_register_ready && (i_register_access == 2'b10);
        write_req    = o_register_ready && i_register_access[0];
        read_ok      = read_req && READABLE && !i_rst;
        write_ok     = write_req && WRITABLE && !i_rst;
        commit       = write_ok && is_last;
        slot_write   = write_ok && !is_last;
        snap_capture = ATOMIC_READ && read_ok && (word_index == '0);
        use_snap     = ATOMIC_READ && snap_valid_q && (word_index != '0);
    end

    assign o_register_active = hit;
    assign o_register_ready  = i_register_valid && hit;
    assign o_register_status = ((read_req && !READABLE) || (write_req && !WRITABLE)) ? 2'b10 : 2'b00;
    assign o_register_value  = i_bit_field_value;

    always_comb begin
        slot_data_d   = slot_data_q;
        slot_strobe_d = slot_strobe_q;
        pending_d     = pending_q;
        if (commit) begin
            pending_d = '0;
        end else if (slot_write) begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
                if (word_index == INDEX_WIDTH'(k)) begin
                    slot_data_d[k]   = i_register_write_data;
                    slot_strobe_d[k] = i_register_strobe;
                    pending_d[k]     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        full_read    = FULL_WIDTH'(i_bit_field_read_data);
        snap_data_d  = snap_data_q;
        snap_valid_d = snap_valid_q;
        if (commit) begin
            snap_valid_d = 1'b0;
        end else if (snap_capture) begin
            snap_data_d  = full_read;
            snap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slot_data_q   <= '0;
            slot_strobe_q <= '0;
            pending_q     <= '0;
            snap_data_q   <= '0;
            snap_valid_q  <= 1'b0;
        end else begin
            slot_data_q   <= slot_data_d;
            slot_strobe_q <= slot_strobe_d;
            pending_q     <= pending_d;
            snap_data_q   <= snap_data_d;
            snap_valid_q  <= snap_valid_d;
        end
    end

    // Slots whose pending bit is clear still supply data but contribute no mask bits.
    always_comb begin
        commit_data = '0;
        commit_mask = '0;
        for (int unsigned k = 0; k + 1 < WORDS; k++) begin
            commit_data[k*BUS_WIDTH +: BUS_WIDTH] = slot_data_q[k];
            commit_mask[k*BUS_WIDTH +: BUS_WIDTH] = pending_q[k] ? slot_strobe_q[k] : '0;
        end
        commit_data[(WORDS-1)*BUS_WIDTH +: BUS_WIDTH] = i_register_write_data;
        commit_mask[(WORDS-1)*BUS_WIDTH +: BUS_WIDTH] = i_register_strobe;
    end

    always_comb begin
        live_word = '0;
        snap_word = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (word_index == INDEX_WIDTH'(k)) begin
                live_word = full_read[k*BUS_WIDTH +: BUS_WIDTH];
                snap_word = snap_data_q[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_comb begin
        o_bit_field_write_valid = commit;
        o_bit_field_read_valid  = read_ok && !use_snap;
        o_bit_field_write_data  = '0;
        o_bit_field_mask        = '0;
        o_register_read_data    = '0;
        if (commit) begin
            o_bit_field_write_data = DATA_WIDTH'(commit_data);
            o_bit_field_mask       = DATA_WIDTH'(commit_mask);
        end else if (read_ok && !use_snap) begin
            o_bit_field_mask = '1;
        end
        if (read_ok) begin
            o_register_read_data = use_snap ? snap_word : live_word;
        end
    end

endmodule

// File: tb/tb_rggen_atomic_wide_register.sv
// Directed scoreboard bench: expectations are queued as each access is driven and checked at the negedge.
module tb_rggen_atomic_wide_register;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [1:0]  access = 2'b00;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = '0;
    logic [31:0] strobe = '0;
    logic [63:0] bf_rdata = '0;
    logic [63:0] bf_value = '0;

    logic        active, ready, wvalid, rvalid;
    logic [1:0]  status;
    logic [31:0] rdata;
    logic [63:0] value, mask, bf_wdata;

    logic        active_ro, ready_ro, wvalid_ro, rvalid_ro;
    logic [1:0]  status_ro;
    logic [31:0] rdata_ro;
    logic [63:0] value_ro, mask_ro, bf_wdata_ro;

    rggen_atomic_wide_register #(
        .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10), .BUS_WIDTH(32), .WORDS(2)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_register_valid(valid), .i_register_access(access), .i_register_address(addr),
        .i_register_write_data(wdata), .i_register_strobe(strobe),
        .o_register_active(active), .o_register_ready(ready), .o_register_status(status),
        .o_register_read_data(rdata), .o_register_value(value),
        .o_bit_field_write_valid(wvalid), .o_bit_field_read_valid(rvalid),
        .o_bit_field_mask(mask), .o_bit_field_write_data(bf_wdata),
        .i_bit_field_read_data(bf_rdata), .i_bit_field_value(bf_value)
    );

    rggen_atomic_wide_register #(
        .WRITABLE(1'b0), .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10), .BUS_WIDTH(32), .WORDS(2)
    ) dut_ro (
        .i_clk(clk), .i_rst(rst),
        .i_register_valid(valid), .i_register_access(access), .i_register_address(addr),
        .i_register_write_data(wdata), .i_register_strobe(strobe),
        .o_register_active(active_ro), .o_register_ready(ready_ro), .o_register_status(status_ro),
        .o_register_read_data(rdata_ro), .o_register_value(value_ro),
        .o_bit_field_write_valid(wvalid_ro), .o_bit_field_read_valid(rvalid_ro),
        .o_bit_field_mask(mask_ro), .o_bit_field_write_data(bf_wdata_ro),
        .i_bit_field_read_data(bf_rdata), .i_bit_field_value(bf_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] observe(string tag);
        case (tag)
            "active":    return 64'(active);
            "ready":     return 64'(ready);
            "status":    return 64'(status);
            "wvalid":    return 64'(wvalid);
            "rvalid":    return 64'(rvalid);
            "wdata":     return bf_wdata;
            "mask":      return mask;
            "rdata":     return 64'(rdata);
            "value":     return value;
            "active_ro": return 64'(active_ro);
            "ready_ro":  return 64'(ready_ro);
            "status_ro": return 64'(status_ro);
            "wvalid_ro": return 64'(wvalid_ro);
            "mask_ro":   return mask_ro;
            default:     return 64'hxxxx_xxxx_xxxx_xxxx;
        endcase
    endfunction

    task automatic push_exp(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic check_queue();
        exp_t        e;
        logic [63:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.tag);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] acc, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] s);
        valid  = v;
        access = acc;
        addr   = a;
        wdata  = d;
        strobe = s;
    endtask

    // Check at the negedge, then let the posedge update state.
    task automatic step();
        @(negedge clk);
        check_queue();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset in force with a commit write driven: no strobes may leak.
        drive(1'b1, 2'b11, 8'h14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push_exp("wvalid", 64'h0);
        push_exp("mask",   64'h0);
        push_exp("wdata",  64'h0);
        push_exp("rdata",  64'h0);
        push_exp("rvalid", 64'h0);
        step();
        rst = 1'b0;
        drive(1'b0, 2'b00, 8'h00, '0, '0);
        bf_value = 64'h0BAD_F00D_1234_5678;
        #1;

        // Two-word write: word 0 held, word 1 commits (posted write).
        drive(1'b1, 2'b11, 8'h10, 32'hAAAA_5555, 32'hFFFF_FFFF);
        push_exp("active", 64'h1);
        push_exp("ready",  64'h1);
        push_exp("status", 64'h0);
        push_exp("wvalid", 64'h0);
        push_exp("mask",   64'h0);
        push_exp("value",  64'h0BAD_F00D_1234_5678);
        step();
        drive(1'b1, 2'b01, 8'h14, 32'h1234_5678, 32'hFFFF_FFFF);
        push_exp("wvalid", 64'h1);
        push_exp("wdata",  64'h1234_5678_AAAA_5555);
        push_exp("mask",   64'hFFFF_FFFF_FFFF_FFFF);
        step();

        // Commit alone: stale slot data, no slot mask.
        drive(1'b1, 2'b11, 8'h14, 32'hCAFE_BABE, 32'h0000_FFFF);
        push_exp("wvalid", 64'h1);
        push_exp("mask",   64'h0000_FFFF_0000_0000);
        push_exp("wdata",  64'hCAFE_BABE_AAAA_5555);
        step();

        // Last write to slot 0 wins, byte-lane address 0x13 still hits word 0.
        drive(1'b1, 2'b11, 8'h10, 32'h1111_1111, 32'h0000_00FF);
        step();
        drive(1'b1, 2'b11, 8'h13, 32'h2222_2222, 32'hFF00_0000);
        push_exp("wvalid", 64'h0);
        step();
        drive(1'b1, 2'b11, 8'h14, 32'h3333_3333, 32'h0000_0000);
        push_exp("wvalid", 64'h1);
        push_exp("mask",   64'h0000_0000_FF00_0000);
        push_exp("wdata",  64'h3333_3333_2222_2222);
        step();

        // Atomic read: word 0 snapshots, word 1 served from snapshot.
        bf_rdata = 64'h1111_2222_3333_4444;
        drive(1'b1, 2'b10, 8'h10, '0, '0);
        push_exp("rdata",  64'h3333_4444);
        push_exp("rvalid", 64'h1);
        push_exp("mask",   64'hFFFF_FFFF_FFFF_FFFF);
        push_exp("wvalid", 64'h0);
        step();
        bf_rdata = 64'h5555_6666_7777_8888;
        drive(1'b1, 2'b10, 8'h14, '0, '0);
        push_exp("rdata",  64'h1111_2222);
        push_exp("rvalid", 64'h0);
        step();

        // Commit clears the snapshot; next word-1 read is live.
        drive(1'b1, 2'b11, 8'h14, 32'h0, 32'hFFFF_FFFF);
        push_exp("wvalid", 64'h1);
        step();
        drive(1'b1, 2'b10, 8'h14, '0, '0);
        push_exp("rdata",  64'h5555_6666);
        push_exp("rvalid", 64'h1);
        step();

        // Address match without valid: active only.
        drive(1'b0, 2'b10, 8'h10, '0, '0);
        push_exp("active", 64'h1);
        push_exp("ready",  64'h0);
        push_exp("rdata",  64'h0);
        push_exp("rvalid", 64'h0);
        step();

        // Reset between slot write and commit discards the held word.
        drive(1'b1, 2'b11, 8'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        step();
        drive(1'b1, 2'b11, 8'h14, 32'h0102_0304, 32'hFFFF_FFFF);
        rst = 1'b1;
        push_exp("wvalid", 64'h0);
        push_exp("mask",   64'h0);
        push_exp("wdata",  64'h0);
        #2;
        check_queue();
        rst = 1'b0;
        push_exp("wvalid", 64'h1);
        push_exp("mask",   64'hFFFF_FFFF_0000_0000);
        push_exp("wdata",  64'h0102_0304_0000_0000);
        step();

        // Non-writable instance and out-of-range address.
        drive(1'b1, 2'b11, 8'h10, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
        push_exp("ready_ro",  64'h1);
        push_exp("status_ro", 64'h2);
        push_exp("wvalid_ro", 64'h0);
        push_exp("mask_ro",   64'h0);
        step();
        drive(1'b1, 2'b11, 8'h14, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
        push_exp("status_ro", 64'h2);
        push_exp("wvalid_ro", 64'h0);
        step();
        drive(1'b1, 2'b11, 8'h18, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
        push_exp("active",    64'h0);
        push_exp("ready",     64'h0);
        push_exp("wvalid",    64'h0);
        push_exp("active_ro", 64'h0);
        push_exp("ready_ro",  64'h0);
        push_exp("status_ro", 64'h0);
        step();

        drive(1'b0, 2'b00, 8'h00, '0, '0);
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
